// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants,
// also intended for the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset
// value so idle-high lines come out of reset already in their idle state.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by a 16x oversampling tick: qualifies the start
// bit at mid-bit, samples data at bit centres, and reports ready/framing/overrun.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 Rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_next;
    logic [SMP_W-1:0]     smp, smp_next;
    logic [BIT_W-1:0]     bitpos, bitpos_next;
    logic [DATA_BITS-1:0] scratch, scratch_next;
    logic                 stop_good;
    logic                 stop_bad;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            smp     <= '0;
            bitpos  <= '0;
            scratch <= '0;
        end else begin
            state   <= state_next;
            smp     <= smp_next;
            bitpos  <= bitpos_next;
            scratch <= scratch_next;
        end
    end

    // Frame sequencing; nothing moves between oversample ticks.
    always_comb begin
        state_next   = state;
        smp_next     = smp;
        bitpos_next  = bitpos;
        scratch_next = scratch;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;
        if (Rxclk_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        smp_next   = '0;
                        state_next = START;
                    end
                end
                START: begin
                    if (smp != SMP_HALF) begin
                        smp_next = smp + 1'b1;
                    end else if (!rx_s) begin
                        smp_next    = '0;
                        bitpos_next = '0;
                        state_next  = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    if (smp != SMP_LAST) begin
                        smp_next = smp + 1'b1;
                    end else begin
                        scratch_next[bitpos] = rx_s;
                        smp_next             = '0;
                        bitpos_next          = bitpos + 1'b1;
                        if (bitpos == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (smp != SMP_LAST) begin
                        smp_next = smp + 1'b1;
                    end else begin
                        stop_good  = rx_s;
                        stop_bad   = !rx_s;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A good stop outranks a simultaneous rdy_clr so the new byte is never lost.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (stop_good) begin
            data      <= scratch;
            rdy       <= 1'b1;
            frame_err <= 1'b0;
            if (rdy_clr) begin
                overrun <= 1'b0;
            end else if (rdy) begin
                overrun <= 1'b1;
            end
        end else begin
            if (stop_bad) begin
                frame_err <= 1'b1;
            end
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
